cen_frac_gen: RTL and testbench

CEN_FRAC_GEN -- requirements
Module: cen_frac_gen

---
 rtl/cen_frac_gen.sv | 121 ++++++++++++
 tb/tb_cen_frac_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cen_frac_gen.sv
// rtl/cen_frac_gen.sv - fractional clock-enable generator, CHANNELS independent num/den accumulators
// Optional per-channel pulse counters enabled by defining CEN_FRAC_GEN_COUNT_EN.
module cen_frac_gen #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 16,
    parameter int DEF_NUM  = 1,
    parameter int DEF_DEN  = 6
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                cfg_wr,
    input  logic [2:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    input  logic                sync,
    input  logic                pause,
    output logic [CHANNELS-1:0] cen,
    input  logic [2:0]          cnt_sel,
    output logic [15:0]         cnt_q
);

`ifdef CEN_FRAC_GEN_COUNT_EN
    logic [15:0] pcnt [CHANNELS];
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [ACC_W-1:0] num_d, num_q;
        logic [ACC_W-1:0] den_d, den_q;
        logic [ACC_W-1:0] acc_d, acc_q;
        logic             cen_d, cen_q;
        logic [ACC_W:0]   sum;
        logic [ACC_W:0]   diff;
        logic             valid;
        logic             cfg_hit;

        assign cfg_hit = cfg_wr && (cfg_ch == 3'(n));
        assign valid   = (den_q != '0) && (num_q != '0) && (num_q <= den_q);
        assign sum     = {1'b0, acc_q} + {1'b0, num_q};
        assign diff    = sum - {1'b0, den_q};

        // Clears (cfg write, sync) take priority over pause so realignment works while frozen.
        always_comb begin
            num_d = num_q;
            den_d = den_q;
            acc_d = acc_q;
            cen_d = 1'b0;
            if (cfg_hit) begin
                num_d = cfg_num;
                den_d = cfg_den;
                acc_d = '0;
            end else if (sync) begin
                acc_d = '0;
            end else if (pause) begin
                acc_d = acc_q;
            end else if (!valid) begin
                acc_d = '0;
            end else if (sum >= {1'b0, den_q}) begin
                acc_d = diff[ACC_W-1:0];
                cen_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                num_q <= ACC_W'(DEF_NUM);
                den_q <= ACC_W'(DEF_DEN);
                acc_q <= '0;
                cen_q <= 1'b0;
            end else begin
                num_q <= num_d;
                den_q <= den_d;
                acc_q <= acc_d;
                cen_q <= cen_d;
            end
        end

        assign cen[n] = cen_q;

`ifdef CEN_FRAC_GEN_COUNT_EN
        logic [15:0] pcnt_d, pcnt_q;

        // Counts pulses as they are issued, so the count already includes the visible cen cycle.
        always_comb begin
            pcnt_d = pcnt_q;
            if (cfg_hit) begin
                pcnt_d = '0;
            end else if (cen_d) begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_d;
            end
        end

        assign pcnt[n] = pcnt_q;
`endif
    end

`ifdef CEN_FRAC_GEN_COUNT_EN
    always_comb begin
        cnt_q = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (cnt_sel == 3'(n)) begin
                cnt_q = pcnt[n];
            end
        end
    end
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_q          = '0;
`endif

endmodule

// File: tb/tb_cen_frac_gen.sv
// tb/tb_cen_frac_gen.sv - directed self-checking bench for cen_frac_gen
module tb_cen_frac_gen;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr  = 1'b0;
    logic [2:0]  cfg_ch  = 3'd0;
    logic [15:0] cfg_num = 16'd0;
    logic [15:0] cfg_den = 16'd0;
    logic        sync    = 1'b0;
    logic        pause   = 1'b0;
    logic [2:0]  cnt_sel = 3'd0;
    logic [3:0]  cen;
    logic [15:0] cnt_q;

    int n_tests = 0;
    int n_fail  = 0;

    cen_frac_gen #(.CHANNELS(4), .ACC_W(16), .DEF_NUM(1), .DEF_DEN(6)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .sync(sync), .pause(pause),
        .cen(cen), .cnt_sel(cnt_sel), .cnt_q(cnt_q)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [15:0] nm, input logic [15:0] dn);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_num = nm;
        cfg_den = dn;
        step();
        cfg_wr  = 1'b0;
    endtask

    function automatic logic [3:0] pat63(input int j);
        pat63 = {(j % 3 == 0), {3{(j % 6 == 0)}}};
    endfunction

    initial begin
        int p0;
        int p1;

        step();
        step();
        check("reset_cen", cen, 4'h0);
        check("reset_cnt", cnt_q, 16'h0);

        reset_n = 1'b1;
        p0 = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            check("defaults", cen, (i % 6 == 0) ? 4'hF : 4'h0);
            if (cen[0]) p0++;
        end
        check("defaults_pulses", p0, 10);
`ifdef CEN_FRAC_GEN_COUNT_EN
        check("cnt_ch0_10", cnt_q, 16'd10);
        cnt_sel = 3'd5;
        #1;
        check("cnt_sel_oob", cnt_q, 16'd0);
        cnt_sel = 3'd0;
`endif

        cfg(3'd1, 16'd2, 16'd5);
        check("cfg_edge_cen", cen, 4'h0);
        p1 = 0;
        for (int j = 1; j <= 100; j++) begin
            step();
            check("ratio_2_5", cen, {(j % 6 == 5), (j % 6 == 5),
                                     (j % 5 == 3) || (j % 5 == 0), (j % 6 == 5)});
            if (cen[1]) p1++;
        end
        check("ratio_2_5_pulses", p1, 40);

        cfg(3'd2, 16'd7, 16'd7);
        check("eq_cfg_edge", cen[2], 1'b0);
        for (int j = 0; j < 10; j++) begin
            step();
            check("num_eq_den", cen[2], 1'b1);
        end
        cfg(3'd2, 16'd0, 16'd0);
        for (int j = 0; j < 10; j++) begin
            check("den_zero", cen[2], 1'b0);
            step();
        end
        cfg(3'd2, 16'd9, 16'd4);
        for (int j = 0; j < 10; j++) begin
            check("num_gt_den", cen[2], 1'b0);
            step();
        end

        cfg(3'd1, 16'd1, 16'd6);
        cfg(3'd2, 16'd1, 16'd6);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_edge", cen, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("pre_pause", cen, 4'h0);
        end
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("paused", cen, 4'h0);
        end
        pause = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("pause_resume", cen, (k == 3 || k == 9) ? 4'hF : 4'h0);
        end

        sync    = 1'b1;
        cfg_wr  = 1'b1;
        cfg_ch  = 3'd3;
        cfg_num = 16'd1;
        cfg_den = 16'd3;
        step();
        sync    = 1'b0;
        cfg_wr  = 1'b0;
        check("sync_cfg_edge", cen, 4'h0);
        for (int j = 1; j <= 14; j++) begin
            if (j == 7) begin
                cfg_wr  = 1'b1;
                cfg_ch  = 3'd5;
                cfg_num = 16'd1;
                cfg_den = 16'd1;
            end
            step();
            cfg_wr = 1'b0;
            check("sync_cfg_run", cen, (j <= 12) ? pat63(j) : 4'h0);
        end

        pause = 1'b1;
        sync  = 1'b1;
        step();
        pause = 1'b0;
        sync  = 1'b0;
        check("pause_sync_edge", cen, 4'h0);
        for (int j = 1; j <= 6; j++) begin
            step();
            check("sync_beats_pause", cen, pat63(j));
        end

`ifdef CEN_FRAC_GEN_COUNT_EN
        cfg(3'd0, 16'd1, 16'd1);
        check("cnt_cfg_clear", cnt_q, 16'd0);
        repeat (65537) step();
        check("cnt_wrap", cnt_q, 16'd1);
`endif

        check("pre_reset_cen0", cen[0], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_cen", cen, 4'h0);
        check("async_reset_cnt", cnt_q, 16'h0);
        step();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check("post_reset", cen, (i == 6) ? 4'hF : 4'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
